rc_unstuffer: RTL and testbench

//   Receive-path bit unstuffer. Sits directly downstream of decode_nrzi and upstream of the CRC checker and byte SIPO.

---
 rtl/rc_pkg.sv | 12 +
 rtl/rc_unstuffer_if.sv | 38 +++
 rtl/rc_sat_counter.sv | 31 +++
 rtl/rc_unstuffer.sv | 126 ++++++++++++
 tb/tb_rc_unstuffer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rc_pkg.sv
// Shared types and constants for the receive-path blocks.
package rc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } unstuff_state_t;

    localparam int USB_MAX_ONES = 6;

endpackage

// File: rtl/rc_unstuffer_if.sv
// Serial bit and framing signals between decode_nrzi, the unstuffer and the CRC/SIPO stage.
interface rc_unstuffer_if;

    logic s_in;
    logic start_unstuffer;
    logic end_unstuffer;
    logic abort;
    logic s_out;
    logic bit_valid;
    logic start_crc;
    logic end_crc;
    logic stuff_error;

    modport master (
        output s_in,
        output start_unstuffer,
        output end_unstuffer,
        output abort,
        input  s_out,
        input  bit_valid,
        input  start_crc,
        input  end_crc,
        input  stuff_error
    );

    modport slave (
        input  s_in,
        input  start_unstuffer,
        input  end_unstuffer,
        input  abort,
        output s_out,
        output bit_valid,
        output start_crc,
        output end_crc,
        output stuff_error
    );

endinterface

// File: rtl/rc_sat_counter.sv
// Saturating event counter, cleared only by the asynchronous reset.
module rc_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rc_unstuffer.sv
// Receive bit unstuffer: drops the stuffed 0 after MAX_ONES 1s and flags stuff violations.
// Optional saturating error counter port err_count enabled by RC_UNSTUFF_ERRCNT_EN.
module rc_unstuffer
    import rc_pkg::*;
#(
    parameter int MAX_ONES = USB_MAX_ONES
) (
    input  logic           clk,
    input  logic           rst_n,
    rc_unstuffer_if.slave  bus
`ifdef RC_UNSTUFF_ERRCNT_EN
    ,
    output logic [7:0]     err_count
`endif
);

    localparam int ONES_W = $clog2(MAX_ONES + 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(MAX_ONES);

    unstuff_state_t    state_q, state_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic              pending_q, pending_d;
    logic              s_out_q, s_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              start_crc_q, start_crc_d;
    logic              end_crc_q, end_crc_d;
    logic              stuff_error_q, stuff_error_d;

    always_comb begin
        state_d       = state_q;
        ones_d        = ones_q;
        pending_d     = pending_q;
        s_out_d       = 1'b0;
        bit_valid_d   = 1'b0;
        start_crc_d   = 1'b0;
        end_crc_d     = 1'b0;
        stuff_error_d = 1'b0;

        if (bus.abort) begin
            state_d   = IDLE;
            ones_d    = '0;
            pending_d = 1'b0;
        end else if (bus.start_unstuffer) begin
            // Start (or restart) always treats this cycle's s_in as bit 0 with a clean run count.
            state_d     = RUN;
            ones_d      = {{(ONES_W-1){1'b0}}, bus.s_in};
            pending_d   = 1'b0;
            s_out_d     = bus.s_in;
            bit_valid_d = 1'b1;
            start_crc_d = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.end_unstuffer) begin
                        state_d   = IDLE;
                        ones_d    = '0;
                        pending_d = 1'b0;
                        end_crc_d = 1'b1;
                    end else if (ones_q == ONES_MAX) begin
                        ones_d = '0;
                        if (bus.s_in) begin
                            state_d       = ERR;
                            stuff_error_d = 1'b1;
                        end
                    end else begin
                        ones_d      = bus.s_in ? ones_q + 1'b1 : '0;
                        s_out_d     = bus.s_in;
                        bit_valid_d = 1'b1;
                        start_crc_d = pending_q;
                        pending_d   = 1'b0;
                    end
                end
                ERR: begin
                    if (bus.end_unstuffer) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ones_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ones_q        <= '0;
            pending_q     <= 1'b0;
            s_out_q       <= 1'b0;
            bit_valid_q   <= 1'b0;
            start_crc_q   <= 1'b0;
            end_crc_q     <= 1'b0;
            stuff_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ones_q        <= ones_d;
            pending_q     <= pending_d;
            s_out_q       <= s_out_d;
            bit_valid_q   <= bit_valid_d;
            start_crc_q   <= start_crc_d;
            end_crc_q     <= end_crc_d;
            stuff_error_q <= stuff_error_d;
        end
    end

    assign bus.s_out       = s_out_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.start_crc   = start_crc_q;
    assign bus.end_crc     = end_crc_q;
    assign bus.stuff_error = stuff_error_q;

`ifdef RC_UNSTUFF_ERRCNT_EN
    // Counting the next-state pulse keeps err_count in step with the visible stuff_error.
    rc_sat_counter #(
        .WIDTH (8)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stuff_error_d),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_rc_unstuffer.sv
// Directed bench for rc_unstuffer with a packet-level reference model and per-cycle compare.
module tb_rc_unstuffer;
    import rc_pkg::*;

    localparam int MAXO = USB_MAX_ONES;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rc_unstuffer_if bus ();

`ifdef RC_UNSTUFF_ERRCNT_EN
    logic [7:0] err_count;
    int         m_errcnt = 0;
    logic [7:0] n_cnt = 8'd0, c_cnt = 8'd0;
`endif

    rc_unstuffer #(.MAX_ONES(MAXO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RC_UNSTUFF_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: packet history and the expected outputs after the next edge.
    bit in_pkt = 1'b0, dead = 1'b0, seen_valid = 1'b0;
    bit hist[$];
    bit n_v = 0, n_s = 0, n_st = 0, n_e = 0, n_err = 0;
    bit c_v = 0, c_s = 0, c_st = 0, c_e = 0, c_err = 0;

    // Observations collected by the compare process.
    int          obs_nv = 0, obs_st = 0, obs_end = 0, obs_err = 0;
    logic [31:0] obs_bits = '0;

    function automatic void model_step(bit b, bit st, bit en, bit ab);
        int trail;
        n_v = 0; n_s = 0; n_st = 0; n_e = 0; n_err = 0;
        if (ab) begin
            in_pkt = 0; dead = 0; hist.delete();
            return;
        end
        if (st) begin
            hist.delete(); in_pkt = 1; dead = 0; seen_valid = 0;
        end else if (en && in_pkt) begin
            if (!dead) n_e = 1;
            in_pkt = 0;
            return;
        end
        if (!in_pkt || dead) return;
        trail = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (!hist[i]) break;
            trail++;
        end
        hist.push_back(b);
        if (trail == MAXO) begin
            if (b) begin
                n_err = 1; dead = 1;
`ifdef RC_UNSTUFF_ERRCNT_EN
                if (m_errcnt < 255) m_errcnt++;
`endif
            end
        end else begin
            n_v = 1; n_s = b; n_st = !seen_valid; seen_valid = 1;
        end
`ifdef RC_UNSTUFF_ERRCNT_EN
        n_cnt = 8'(m_errcnt);
`endif
    endfunction

    function automatic void model_reset();
        in_pkt = 0; dead = 0; seen_valid = 0; hist.delete();
        n_v = 0; n_s = 0; n_st = 0; n_e = 0; n_err = 0;
`ifdef RC_UNSTUFF_ERRCNT_EN
        m_errcnt = 0; n_cnt = 8'd0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_v <= 0; c_s <= 0; c_st <= 0; c_e <= 0; c_err <= 0;
`ifdef RC_UNSTUFF_ERRCNT_EN
            c_cnt <= 8'd0;
`endif
        end else begin
            c_v <= n_v; c_s <= n_s; c_st <= n_st; c_e <= n_e; c_err <= n_err;
`ifdef RC_UNSTUFF_ERRCNT_EN
            c_cnt <= n_cnt;
`endif
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            bit bad;
            @(negedge clk);
            bad = (bus.bit_valid !== c_v) || (c_v && (bus.s_out !== c_s)) ||
                  (bus.start_crc !== c_st) || (bus.end_crc !== c_e) ||
                  (bus.stuff_error !== c_err);
`ifdef RC_UNSTUFF_ERRCNT_EN
            if (err_count !== c_cnt) bad = 1;
`endif
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL cycle_compare t=%0t got v=%b s=%b st=%b end=%b err=%b want v=%b s=%b st=%b end=%b err=%b",
                         $time, bus.bit_valid, bus.s_out, bus.start_crc, bus.end_crc, bus.stuff_error,
                         c_v, c_s, c_st, c_e, c_err);
            end
            if (bus.bit_valid === 1'b1) begin
                obs_nv++;
                obs_bits = {obs_bits[30:0], bus.s_out};
            end
            if (bus.start_crc === 1'b1) obs_st++;
            if (bus.end_crc === 1'b1) obs_end++;
            if (bus.stuff_error === 1'b1) obs_err++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic st, input logic en, input logic ab);
        @(posedge clk);
        #1;
        bus.s_in = b; bus.start_unstuffer = st; bus.end_unstuffer = en; bus.abort = ab;
        model_step(b, st, en, ab);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [31:0] v, input int n, input bit with_end);
        for (int i = n - 1; i >= 0; i--) drive(v[i], (i == n - 1), 1'b0, 1'b0);
        if (with_end) drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    int s_nv, s_st, s_end, s_err;
    task automatic snap();
        s_nv = obs_nv; s_st = obs_st; s_end = obs_end; s_err = obs_err;
    endtask

    initial begin
        bus.s_in = 0; bus.start_unstuffer = 0; bus.end_unstuffer = 0; bus.abort = 0;
        #2 rst_n = 1'b0;
        #1 check("reset_bit_valid", int'(bus.bit_valid), 0);
        check("reset_stuff_error", int'(bus.stuff_error), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        // 1: plain byte, MSB first
        snap(); send(32'hA3, 8, 1'b1); idle(3);
        check("t1_valid_count", obs_nv - s_nv, 8);
        check("t1_bits", int'(obs_bits[7:0]), 8'hA3);
        check("t1_start_crc", obs_st - s_st, 1);
        check("t1_end_crc", obs_end - s_end, 1);

        // 2: stuffed 0 after six 1s
        snap(); send(32'hFD, 8, 1'b1); idle(3);
        check("t2_valid_count", obs_nv - s_nv, 7);
        check("t2_bits", int'(obs_bits[6:0]), 7'h7F);
        check("t2_no_error", obs_err - s_err, 0);
        check("t2_end_crc", obs_end - s_end, 1);

        // 3: seven 1s is a stuff violation; junk in ERR is ignored
        snap(); send(32'h7F, 7, 1'b0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
        drive(0, 0, 1, 0); idle(3);
        check("t3_error", obs_err - s_err, 1);
        check("t3_valid_count", obs_nv - s_nv, 6);
        check("t3_no_end_crc", obs_end - s_end, 0);
`ifdef RC_UNSTUFF_ERRCNT_EN
        check("t3_err_count", int'(err_count), 1);
`endif

        // 4: abort after three bits, then a clean packet
        snap(); send(32'h5, 3, 1'b0); drive(1, 0, 0, 1); idle(3);
        check("t4_abort_valid", obs_nv - s_nv, 3);
        check("t4_abort_no_end", obs_end - s_end, 0);
        snap(); send(32'h6, 4, 1'b1); idle(3);
        check("t4_after_valid", obs_nv - s_nv, 4);
        check("t4_after_bits", int'(obs_bits[3:0]), 4'h6);
        check("t4_after_end", obs_end - s_end, 1);

        // 5: restart after four 1s clears the run
        snap(); send(32'hF, 4, 1'b0); send(32'h7F, 7, 1'b0); drive(0, 0, 1, 0); idle(3);
        check("t5_valid_count", obs_nv - s_nv, 10);
        check("t5_error", obs_err - s_err, 1);
        check("t5_start_crc", obs_st - s_st, 2);
        check("t5_no_end", obs_end - s_end, 0);
`ifdef RC_UNSTUFF_ERRCNT_EN
        check("t5_err_count", int'(err_count), 2);
`endif

        // 6: async reset with five 1s pending
        send(32'h1F, 5, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; model_reset();
        #1 check("t6_rst_bit_valid", int'(bus.bit_valid), 0);
        check("t6_rst_s_out", int'(bus.s_out), 0);
        check("t6_rst_start_crc", int'(bus.start_crc), 0);
`ifdef RC_UNSTUFF_ERRCNT_EN
        check("t6_rst_err_count", int'(err_count), 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);
        snap(); send(32'hFD, 8, 1'b1); idle(3);
        check("t6_valid_count", obs_nv - s_nv, 7);
        check("t6_no_error", obs_err - s_err, 0);
        check("t6_end_crc", obs_end - s_end, 1);

        // 7: start and end together in IDLE, start wins
        snap(); drive(0, 1, 1, 0); drive(1, 0, 0, 0); drive(0, 0, 1, 0); idle(3);
        check("t7_valid_count", obs_nv - s_nv, 2);
        check("t7_bits", int'(obs_bits[1:0]), 2'b01);
        check("t7_end_crc", obs_end - s_end, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
